// File: rtl/select_unit_pipelined.sv
// Pipelined minimum-energy path selector: registered comparison tree over N_B
// candidates, global-stall valid/ready pipeline, S = ceil(levels / LVL_PER_STG).
module select_unit_pipelined #(
   parameter int N_B         = 8,
   parameter int H_DEPTH     = 4,
   parameter int B_WIDTH     = 8,
   parameter int LVL_PER_STG = 2,
   localparam int IDX_W      = (N_B > 1) ? $clog2(N_B) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_B*2*B_WIDTH-1:0]     path_energies,
   input  logic [N_B*2*H_DEPTH-1:0]     path_histories,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [2*B_WIDTH-1:0]         selected_path_energy,
   output logic [2*H_DEPTH-1:0]         selected_path_history,
   output logic [IDX_W-1:0]             selected_index
);

   localparam int EW     = 2 * B_WIDTH;
   localparam int HW     = 2 * H_DEPTH;
   localparam int LEVELS = (N_B > 1) ? $clog2(N_B) : 0;
   localparam int P      = 1 << LEVELS;
   localparam int S      = (LEVELS == 0) ? 1 : (LEVELS + LVL_PER_STG - 1) / LVL_PER_STG;

   logic         stall;
   logic [S-1:0] vld;

   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = vld[S-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
      end else if (!stall) begin
         vld[0] <= in_valid;
         for (int s = 1; s < S; s++) begin
            vld[s] <= vld[s-1];
         end
      end
   end

   // Level 0 holds the leaves; level l reduces pairs of level l-1. A level is
   // registered when it closes a stage (every LVL_PER_STG levels, and the root).
   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int NN  = P >> l;
      localparam bit BND = (l == LEVELS) || ((l != 0) && ((l % LVL_PER_STG) == 0));

      logic [EW-1:0]    c_e [NN];
      logic [HW-1:0]    c_h [NN];
      logic [IDX_W-1:0] c_i [NN];
      logic [EW-1:0]    t_e [NN];
      logic [HW-1:0]    t_h [NN];
      logic [IDX_W-1:0] t_i [NN];

      if (l == 0) begin : g_leaf
         for (genvar n = 0; n < NN; n++) begin : g_n
            if (n < N_B) begin : g_real
               assign c_e[n] = path_energies[n*EW +: EW];
               assign c_h[n] = path_histories[n*HW +: HW];
               assign c_i[n] = IDX_W'(n);
            end else begin : g_pad
               assign c_e[n] = '1;
               assign c_h[n] = '0;
               assign c_i[n] = '0;
            end
         end
      end else begin : g_node
         for (genvar n = 0; n < NN; n++) begin : g_n
            // Ties go left: the left subtree always carries the lower indices,
            // and pads only ever sit to the right of every real leaf.
            logic sel_a;
            assign sel_a  = (g_lvl[l-1].t_e[2*n] <= g_lvl[l-1].t_e[2*n+1]);
            assign c_e[n] = sel_a ? g_lvl[l-1].t_e[2*n] : g_lvl[l-1].t_e[2*n+1];
            assign c_h[n] = sel_a ? g_lvl[l-1].t_h[2*n] : g_lvl[l-1].t_h[2*n+1];
            assign c_i[n] = sel_a ? g_lvl[l-1].t_i[2*n] : g_lvl[l-1].t_i[2*n+1];
         end
      end

      if (BND) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int n = 0; n < NN; n++) begin
                  t_e[n] <= '0;
                  t_h[n] <= '0;
                  t_i[n] <= '0;
               end
            end else if (!stall) begin
               t_e <= c_e;
               t_h <= c_h;
               t_i <= c_i;
            end
         end
      end else begin : g_comb
         assign t_e = c_e;
         assign t_h = c_h;
         assign t_i = c_i;
      end
   end

   assign selected_path_energy  = g_lvl[LEVELS].t_e[0];
   assign selected_path_history = g_lvl[LEVELS].t_h[0];
   assign selected_index        = g_lvl[LEVELS].t_i[0];

endmodule

// File: tb/tb_select_unit_pipelined.sv
// Scoreboard bench for select_unit_pipelined: four configurations run side by
// side, each with directed beats, backpressure, mid-flight reset and a random stream.
module tb_select_unit_pipelined;

   localparam int H_DEPTH = 4;
   localparam int B_WIDTH = 8;
   localparam int EW      = 2 * B_WIDTH;
   localparam int HW      = 2 * H_DEPTH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit done [4];

   task automatic chk(input int cfg, input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, name, act, exp);
      end
   endtask

   for (genvar C = 0; C < 4; C++) begin : g_cfg
      localparam int NB    = (C == 0) ? 8 : (C == 1) ? 5 : (C == 2) ? 1 : 32;
      localparam int LPS   = (C == 3) ? 1 : 2;
      localparam int IW    = (NB > 1) ? $clog2(NB) : 1;
      localparam int LV    = (NB > 1) ? $clog2(NB) : 0;
      localparam int S     = (LV == 0) ? 1 : (LV + LPS - 1) / LPS;
      localparam int NRAND = (C == 3) ? 1000 : 150;

      logic             rst       = 1'b1;
      logic             in_valid  = 1'b0;
      logic             out_ready = 1'b1;
      logic             in_ready;
      logic             out_valid;
      logic [NB*EW-1:0] pe = '0;
      logic [NB*HW-1:0] ph = '0;
      logic [EW-1:0]    se;
      logic [HW-1:0]    sh;
      logic [IW-1:0]    si;

      select_unit_pipelined #(
         .N_B(NB), .H_DEPTH(H_DEPTH), .B_WIDTH(B_WIDTH), .LVL_PER_STG(LPS)
      ) dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
         .path_energies(pe), .path_histories(ph),
         .out_valid(out_valid), .out_ready(out_ready),
         .selected_path_energy(se), .selected_path_history(sh), .selected_index(si)
      );

      logic [EW-1:0] q_e [$];
      logic [HW-1:0] q_h [$];
      int            q_i [$];
      int            q_a [$];
      int            adv     = 0;
      int            out_cnt = 0;

      // Reference: linear scan for the strictly smallest energy, first index wins ties.
      always @(negedge clk) begin
         int best;
         chk(C, "in_ready", in_ready, !(out_valid && !out_ready));
         if (rst) begin
            q_e.delete(); q_h.delete(); q_i.delete(); q_a.delete();
         end else begin
            if (out_valid) begin
               if (q_e.size() == 0) begin
                  chk(C, "unexpected output", 1, 0);
               end else begin
                  chk(C, "energy",  se, q_e[0]);
                  chk(C, "history", sh, q_h[0]);
                  chk(C, "index",   si, q_i[0]);
                  chk(C, "latency", adv - q_a[0], S);
                  if (out_ready) begin
                     void'(q_e.pop_front()); void'(q_h.pop_front());
                     void'(q_i.pop_front()); void'(q_a.pop_front());
                     out_cnt++;
                  end
               end
            end
            if (in_valid && in_ready) begin
               best = 0;
               for (int i = 1; i < NB; i++)
                  if (pe[i*EW +: EW] < pe[best*EW +: EW]) best = i;
               q_e.push_back(pe[best*EW +: EW]);
               q_h.push_back(ph[best*HW +: HW]);
               q_i.push_back(best);
               q_a.push_back(adv);
            end
            if (!(out_valid && !out_ready)) adv++;
         end
      end

      logic [NB*EW-1:0] e_t;
      logic [NB*HW-1:0] h_t;

      task automatic tick();
         @(posedge clk); #1;
      endtask

      task automatic send(input bit rnd);
         int  n;
         bit  ok;
         n = 0; ok = 1'b0;
         in_valid = 1'b1; pe = e_t; ph = h_t;
         while (!ok && n < 500) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; n++;
         end
         in_valid = 1'b0;
         chk(C, "beat accepted", ok, 1);
      endtask

      task automatic rand_beat();
         int mode;
         mode = $urandom_range(0, 2);
         for (int i = 0; i < NB; i++) begin
            if (mode == 0)      e_t[i*EW +: EW] = EW'($urandom_range(0, 7));
            else if (mode == 1) e_t[i*EW +: EW] = EW'($urandom);
            else                e_t[i*EW +: EW] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'hFFFE;
            h_t[i*HW +: HW] = HW'($urandom);
         end
      endtask

      function automatic int dir_e(input int b, input int i);
         int t0 [8];
         t0 = '{50, 30, 70, 30, 90, 10, 10, 200};
         case (C)
            0:       return t0[i];
            1:       return (b == 0) ? 32'hFFFF : ((i == 4) ? 3 : 9);
            2:       return 123;
            default: return $urandom_range(0, 65535);
         endcase
      endfunction

      task automatic drain(input int lim);
         int n;
         n = 0;
         out_ready = 1'b1;
         while (q_e.size() != 0 && n < lim) begin
            tick(); n++;
         end
         chk(C, "drain empty", q_e.size(), 0);
      endtask

      initial begin : stim
         int ndir, nb, n, c0;
         logic [EW-1:0] cap_e;
         logic [HW-1:0] cap_h;
         logic [IW-1:0] cap_i;

         repeat (3) @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         chk(C, "reset out_valid", out_valid, 0);
         chk(C, "reset in_ready",  in_ready, 1);
         chk(C, "reset energy",    se, 0);
         chk(C, "reset history",   sh, 0);
         chk(C, "reset index",     si, 0);
         tick();

         ndir = (C == 1) ? 2 : 1;
         out_ready = 1'b1;
         for (int b = 0; b < ndir; b++) begin
            for (int i = 0; i < NB; i++) begin
               e_t[i*EW +: EW] = EW'(dir_e(b, i));
               h_t[i*HW +: HW] = HW'($urandom);
            end
            send(1'b0);
         end
         drain(50);

         out_ready = 1'b0;
         c0 = out_cnt;
         fork
            begin
               for (int k = 0; k < 4; k++) begin
                  rand_beat();
                  send(1'b0);
               end
            end
            begin
               n = 0;
               do begin
                  @(negedge clk); n++;
               end while (!out_valid && n < 50);
               chk(C, "bp first result", out_valid, 1);
               cap_e = se; cap_h = sh; cap_i = si;
               repeat (3) begin
                  @(negedge clk);
                  chk(C, "bp hold valid",   out_valid, 1);
                  chk(C, "bp in_ready low", in_ready, 0);
                  chk(C, "bp hold energy",  se, cap_e);
                  chk(C, "bp hold history", sh, cap_h);
                  chk(C, "bp hold index",   si, cap_i);
               end
               @(posedge clk); #1 out_ready = 1'b1;
            end
         join
         drain(50);
         chk(C, "bp result count", out_cnt - c0, 4);

         out_ready = 1'b0;
         nb = (S >= 2) ? 2 : 1;
         for (int k = 0; k < nb; k++) begin
            rand_beat();
            send(1'b0);
         end
         rst = 1'b1;
         tick();
         rst = 1'b0;
         out_ready = 1'b1;
         repeat (4) begin
            @(negedge clk);
            chk(C, "flush out_valid", out_valid, 0);
            chk(C, "flush in_ready",  in_ready, 1);
         end
         tick();

         for (int k = 0; k < NRAND; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               out_ready = ($urandom_range(0, 1) == 1);
               tick();
            end
            rand_beat();
            send(1'b1);
         end
         drain(100);
         done[C] = 1'b1;
      end
   end

   initial begin : summary
      int n;
      n = 0;
      while (!(done[0] && done[1] && done[2] && done[3]) && n < 60000) begin
         @(posedge clk); n++;
      end
      if (!(done[0] && done[1] && done[2] && done[3])) begin
         fails++;
         $display("FAIL global timeout: configurations did not complete");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/select_unit_pipelined.md
Name: select_unit_pipelined

Overview:
Parametrised, pipelined minimum-energy path selector for the Viterbi/MLSD back end. It accepts N_B candidate path energies with their symbol histories in one beat and returns the minimum-energy path, its history and its index. It uses a registered comparison tree with any N_B ≥ 1, configurable pipeline depth, and valid/ready flow control. It sits between the branch-metric/ACS stage and the traceback/decision output.

Parameters:
N_B, 8, number of candidate paths (≥1, any value, not limited to powers of two)
H_DEPTH, 4, history length per path (2-bit signed symbols)
B_WIDTH, 8, energies are 2*B_WIDTH bits unsigned
LVL_PER_STG, 2, comparison-tree levels per pipeline register (≥1)
IDX_W, max(1,$clog2(N_B)), width of selected index (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
path_energies  in  [2*B_WIDTH-1:0] x N_B  candidate energies, unsigned
path_histories  in  signed [1:0] x N_B x H_DEPTH  candidate histories
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
selected_path_energy  out  2*B_WIDTH  minimum energy
selected_path_history  out  signed [1:0] x H_DEPTH  history of the winner
selected_index  out  IDX_W  index of the winner in 0..N_B-1

Behaviour:
- LEVELS = $clog2(N_B), which is 0 when N_B=1. Stage count S = max(1, ceil(LEVELS/LVL_PER_STG)). Latency from input acceptance to out_valid is exactly S cycles when there is no stall.
- Tree: leaves padded to 2**LEVELS. Pad leaves carry energy all-ones, history 0 and index 0, and never win against a real leaf of equal energy.
- Each node compares {energy, index}. Strictly lower energy wins; on equal energy the lower index wins. Result is deterministic.
- A register bank (valid bit plus energy, history and index) sits after every LVL_PER_STG levels. The final bank drives the outputs. If LEVELS is not a multiple of LVL_PER_STG, the last stage holds the remaining levels.
- N_B=1: a single register stage and index 0.
- Flow control: stall = out_valid & ~out_ready. in_ready = ~stall, purely combinational from out_valid and out_ready.
- When stall=1, all stage registers hold, including valid bits, and no input is accepted.
- When stall=0, all stages advance one step. Bubbles (valid=0) propagate. A beat is accepted iff in_valid & in_ready.
- No bubble collapsing: the whole pipeline stalls globally, which keeps the RTL simple and timing-safe.
- Outputs are stable while out_valid=1 and out_ready=0.
- Datapath registers in bubble stages may hold stale data. Outputs are defined only when out_valid=1.
- Reset:
  - All valid bits go to 0; out_valid=0.
  - selected_path_energy, selected_path_history and selected_index reset to 0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation flushes all in-flight beats with no output produced.
  - Reset takes priority over stall.
- Back-to-back: throughput is one beat per cycle when out_ready is held at 1.
- Energy arithmetic is compare only, with no addition, so there is no overflow. The all-ones energy is a legal real input and beats pad leaves by index.

Test Plan:
- N_B=8, LVL_PER_STG=2 (S=2). Energies {50,30,70,30,90,10,10,200}, out_ready=1. Expect out_valid exactly 2 cycles later, energy 10, index 5 (tie with 6 broken low), and history equal to path 5's history.
- N_B=5 (padding, LEVELS=3, S=2). All energies 16'hFFFF. Expect index 0 and energy FFFF, with no pad leaf selected. Then energies {9,9,9,9,3} -> index 4.
- Backpressure: stream 4 beats with in_valid=1 and hold out_ready=0 once the first result appears. Expect in_ready to drop the same cycle and outputs to hold for 3 cycles. Releasing out_ready delivers all 4 results in order with none lost or duplicated.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle before the first result. Expect out_valid to stay 0 for the following 4 cycles and in_ready=1 after reset.
- N_B=1. Beat energy 123 -> out_valid after 1 cycle, energy 123, index 0, history passthrough. N_B=32, LVL_PER_STG=1 (S=5): a random 1000-beat stream with random out_ready is checked against a reference model for the minimum/lowest-index rule and latency.
